utm_tape_controller: RTL and testbench

//   Sequential tape/head/state engine that drives the combinational Turing-machine transition

---
 rtl/utm_tape_controller.sv | 151 +++++++++++++++
 tb/tb_utm_tape_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/utm_tape_controller.sv
// Tape, head and state sequencer around an external combinational Turing-machine table.
// Each step is LOOKUP (table settles) then COMMIT (tape write, head move, state update).
module utm_tape_controller #(
  parameter int unsigned TAPE_LEN   = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned HEAD_INIT  = 8,
  parameter logic [2:0]  HALT_STATE = 3'd7,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [2:0]       load_sym,
  input  logic             start,
  input  logic [AW-1:0]    rd_addr,
  output logic [2:0]       rd_sym,
  output logic [7:0]       tt_in,
  input  logic [7:0]       tt_out,
  output logic [2:0]       state,
  output logic [AW-1:0]    head,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] step_count
);

  localparam logic [AW-1:0] LP_HEAD_INIT = AW'(HEAD_INIT);
  localparam logic [AW-1:0] LP_LAST      = AW'(TAPE_LEN - 1);
  localparam logic [AW:0]   LP_LEN       = (AW+1)'(TAPE_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_COMMIT,
    S_HALTED
  } fsm_t;

  fsm_t             r_fsm;
  logic [2:0]       r_tape [TAPE_LEN];
  logic [2:0]       r_state;
  logic [AW-1:0]    r_head;
  logic             r_busy;
  logic             r_halted;
  logic             r_fault;
  logic [CNT_W-1:0] r_step;

  logic [2:0] w_head_sym;
  logic [2:0] w_rd_sym;
  logic [2:0] w_next_state;
  logic [2:0] w_new_sym;
  logic       w_dir;
  logic       w_edge;
  logic       w_load_ok;
  logic       w_unused;

  assign w_next_state = tt_out[7:5];
  assign w_new_sym    = tt_out[4:2];
  assign w_dir        = tt_out[1];
  assign w_unused     = tt_out[0];

  // A move off either end of the tape is a fault; the head stays put.
  assign w_edge    = ((r_head == '0) && !w_dir) || ((r_head == LP_LAST) && w_dir);
  assign w_load_ok = load_en && ({1'b0, load_addr} < LP_LEN);

  always_comb begin
    w_head_sym = '0;
    if ({1'b0, r_head} < LP_LEN) begin
      w_head_sym = r_tape[r_head];
    end
  end

  always_comb begin
    w_rd_sym = '0;
    if ({1'b0, rd_addr} < LP_LEN) begin
      w_rd_sym = r_tape[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm    <= S_IDLE;
      r_state  <= '0;
      r_head   <= LP_HEAD_INIT;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_fault  <= 1'b0;
      r_step   <= '0;
      for (int unsigned i = 0; i < TAPE_LEN; i++) begin
        r_tape[i] <= '0;
      end
    end else begin
      case (r_fsm)
        S_IDLE, S_HALTED: begin
          // A load in the same cycle as start lands before the first LOOKUP reads the tape.
          if (w_load_ok) begin
            r_tape[load_addr] <= load_sym;
          end
          if (start) begin
            r_state  <= '0;
            r_head   <= LP_HEAD_INIT;
            r_step   <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_busy   <= 1'b1;
            r_fsm    <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_fsm <= S_COMMIT;
        end
        S_COMMIT: begin
          r_tape[r_head] <= w_new_sym;
          r_state        <= w_next_state;
          if (r_step != '1) begin
            r_step <= r_step + 1'b1;
          end
          if (w_edge) begin
            r_fault  <= 1'b1;
            r_halted <= 1'b1;
            r_busy   <= 1'b0;
            r_fsm    <= S_HALTED;
          end else begin
            r_head <= w_dir ? (r_head + 1'b1) : (r_head - 1'b1);
            if (w_next_state == HALT_STATE) begin
              r_halted <= 1'b1;
              r_busy   <= 1'b0;
              r_fsm    <= S_HALTED;
            end else begin
              r_fsm <= S_LOOKUP;
            end
          end
        end
        default: begin
          r_fsm  <= S_IDLE;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign tt_in      = {r_state, w_head_sym, 2'b00};
  assign rd_sym     = w_rd_sym;
  assign state      = r_state;
  assign head       = r_head;
  assign busy       = r_busy;
  assign halted     = r_halted;
  assign fault      = r_fault;
  assign step_count = r_step;

endmodule

// File: tb/tb_utm_tape_controller.sv
// Directed bench for utm_tape_controller with a small behavioural transition table.
module tb_utm_tape_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [2:0]  load_sym = '0;
  logic        start = 1'b0;
  logic [3:0]  rd_addr = '0;
  logic [2:0]  rd_sym;
  logic [7:0]  tt_in;
  logic [7:0]  tt_out;
  logic [2:0]  state;
  logic [3:0]  head;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [15:0] step_count;

  int n_checks = 0;
  int n_errors = 0;
  int mode = 0;

  utm_tape_controller #(
    .TAPE_LEN(16), .AW(4), .HEAD_INIT(8), .HALT_STATE(3'd7), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_sym(load_sym), .start(start), .rd_addr(rd_addr), .rd_sym(rd_sym),
    .tt_in(tt_in), .tt_out(tt_out), .state(state), .head(head), .busy(busy),
    .halted(halted), .fault(fault), .step_count(step_count)
  );

  always #5 clk = ~clk;

  // Transition table: {next_state, new_sym, dir, 0}
  always_comb begin
    logic [2:0] st;
    logic [2:0] sy;
    st = tt_in[7:5];
    sy = tt_in[4:2];
    tt_out = 8'h00;
    case (mode)
      1: tt_out = (st == 3'd0 && sy == 3'd1) ? {3'd7, 3'd0, 1'b1, 1'b0} : {3'd7, sy, 1'b1, 1'b0};
      2: case ({st, sy})
           6'o00:   tt_out = {3'd1, 3'd1, 1'b1, 1'b0};
           6'o01:   tt_out = {3'd1, 3'd1, 1'b0, 1'b0};
           6'o10:   tt_out = {3'd0, 3'd1, 1'b0, 1'b0};
           6'o11:   tt_out = {3'd7, 3'd1, 1'b1, 1'b0};
           default: tt_out = {3'd7, sy, 1'b1, 1'b0};
         endcase
      3: tt_out = {3'd0, sy, 1'b0, 1'b0};
      4: tt_out = {3'd0, 3'd5, 1'b1, 1'b0};
      default: tt_out = 8'h00;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] a, input logic [2:0] s);
    load_en = 1'b1; load_addr = a; load_sym = s;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault got=%0b exp=0", fault); end
    n_checks++; if (step_count !== 16'd0) begin n_errors++; $display("FAIL reset_steps got=%0d exp=0", step_count); end
    n_checks++; if (tt_in !== 8'h00) begin n_errors++; $display("FAIL reset_tt_in got=%h exp=00", tt_in); end
    n_checks++; if (head !== 4'd8) begin n_errors++; $display("FAIL reset_head got=%0d exp=8", head); end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      n_checks++;
      if (rd_sym !== 3'd0) begin n_errors++; $display("FAIL reset_tape[%0d] got=%0d exp=0", i, rd_sym); end
    end
  endtask

  task automatic test_single_step();
    do_reset();
    mode = 1;
    do_load(4'd8, 3'd1);
    n_checks++; if (tt_in !== 8'h04) begin n_errors++; $display("FAIL single_tt_in got=%h exp=04", tt_in); end
    do_start();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy got=%0b exp=1", busy); end
    tick();
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL single_early_halt got=%0b exp=0", halted); end
    tick();
    rd_addr = 4'd8; #1;
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL single_halted got=%0b exp=1", halted); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy_end got=%0b exp=0", busy); end
    n_checks++; if (rd_sym !== 3'd0) begin n_errors++; $display("FAIL single_tape8 got=%0d exp=0", rd_sym); end
    n_checks++; if (head !== 4'd9) begin n_errors++; $display("FAIL single_head got=%0d exp=9", head); end
    n_checks++; if (state !== 3'd7) begin n_errors++; $display("FAIL single_state got=%0d exp=7", state); end
    n_checks++; if (step_count !== 16'd1) begin n_errors++; $display("FAIL single_steps got=%0d exp=1", step_count); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL single_fault got=%0b exp=0", fault); end
  endtask

  task automatic test_busy_beaver();
    do_reset();
    mode = 2;
    do_start();
    repeat (11) tick();
    n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL bb_early_halt got=%0b exp=0", halted); end
    tick();
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL bb_halted got=%0b exp=1", halted); end
    n_checks++; if (step_count !== 16'd6) begin n_errors++; $display("FAIL bb_steps got=%0d exp=6", step_count); end
    n_checks++; if (head !== 4'd8) begin n_errors++; $display("FAIL bb_head got=%0d exp=8", head); end
    n_checks++; if (state !== 3'd7) begin n_errors++; $display("FAIL bb_state got=%0d exp=7", state); end
    n_checks++; if (tt_in !== 8'hE4) begin n_errors++; $display("FAIL bb_tt_in got=%h exp=e4", tt_in); end
    for (int i = 0; i < 16; i++) begin
      logic [2:0] exp_sym;
      exp_sym = (i >= 6 && i <= 9) ? 3'd1 : 3'd0;
      rd_addr = 4'(i);
      #1;
      n_checks++;
      if (rd_sym !== exp_sym) begin n_errors++; $display("FAIL bb_tape[%0d] got=%0d exp=%0d", i, rd_sym, exp_sym); end
    end
  endtask

  task automatic test_left_edge();
    do_reset();
    mode = 3;
    do_start();
    repeat (16) tick();
    n_checks++; if (head !== 4'd0) begin n_errors++; $display("FAIL edge_head8 got=%0d exp=0", head); end
    n_checks++; if (fault !== 1'b0 || halted !== 1'b0) begin n_errors++; $display("FAIL edge_early got=%0b%0b exp=00", fault, halted); end
    tick();
    tick();
    n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL edge_fault got=%0b exp=1", fault); end
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL edge_halted got=%0b exp=1", halted); end
    n_checks++; if (head !== 4'd0) begin n_errors++; $display("FAIL edge_head got=%0d exp=0", head); end
    n_checks++; if (step_count !== 16'd9) begin n_errors++; $display("FAIL edge_steps got=%0d exp=9", step_count); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL edge_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_restart();
    // From the faulted HALTED state; tape is all zero, so mode 1 takes its default row.
    mode = 1;
    do_start();
    n_checks++; if (halted !== 1'b0 || fault !== 1'b0) begin n_errors++; $display("FAIL restart_clear got=%0b%0b exp=00", halted, fault); end
    n_checks++; if (head !== 4'd8 || step_count !== 16'd0) begin n_errors++; $display("FAIL restart_init head=%0d steps=%0d exp=8,0", head, step_count); end
    tick();
    tick();
    n_checks++; if (halted !== 1'b1 || head !== 4'd9) begin n_errors++; $display("FAIL restart_end halted=%0b head=%0d exp=1,9", halted, head); end
  endtask

  task automatic test_busy_ignore();
    do_reset();
    mode = 3;
    do_start();
    repeat (3) tick();
    load_en = 1'b1; load_addr = 4'd3; load_sym = 3'd5; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    rd_addr = 4'd3; #1;
    n_checks++; if (rd_sym !== 3'd0) begin n_errors++; $display("FAIL ignore_tape3 got=%0d exp=0", rd_sym); end
    n_checks++; if (step_count !== 16'd2) begin n_errors++; $display("FAIL ignore_steps got=%0d exp=2", step_count); end
    n_checks++; if (head !== 4'd6) begin n_errors++; $display("FAIL ignore_head got=%0d exp=6", head); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ignore_busy got=%0b exp=1", busy); end
  endtask

  task automatic test_reset_in_commit();
    do_reset();
    mode = 4;
    do_start();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_addr = 4'd8; #1;
    n_checks++; if (rd_sym !== 3'd0) begin n_errors++; $display("FAIL rstc_tape8 got=%0d exp=0", rd_sym); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstc_busy got=%0b exp=0", busy); end
    n_checks++; if (head !== 4'd8) begin n_errors++; $display("FAIL rstc_head got=%0d exp=8", head); end
    n_checks++; if (step_count !== 16'd0) begin n_errors++; $display("FAIL rstc_steps got=%0d exp=0", step_count); end
    n_checks++; if (state !== 3'd0 || tt_in !== 8'h00) begin n_errors++; $display("FAIL rstc_state state=%0d tt_in=%h exp=0,00", state, tt_in); end
    tick();
    n_checks++; if (busy !== 1'b0 || head !== 4'd8) begin n_errors++; $display("FAIL rstc_idle busy=%0b head=%0d exp=0,8", busy, head); end
  endtask

  task automatic test_load_with_start();
    do_reset();
    mode = 1;
    load_en = 1'b1; load_addr = 4'd8; load_sym = 3'd1; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    tick();
    tick();
    rd_addr = 4'd8; #1;
    n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL ls_halted got=%0b exp=1", halted); end
    n_checks++; if (rd_sym !== 3'd0) begin n_errors++; $display("FAIL ls_tape8 got=%0d exp=0", rd_sym); end
    n_checks++; if (head !== 4'd9) begin n_errors++; $display("FAIL ls_head got=%0d exp=9", head); end
    n_checks++; if (state !== 3'd7) begin n_errors++; $display("FAIL ls_state got=%0d exp=7", state); end
    n_checks++; if (step_count !== 16'd1) begin n_errors++; $display("FAIL ls_steps got=%0d exp=1", step_count); end
    n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL ls_fault got=%0b exp=0", fault); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_step();
    test_busy_beaver();
    test_left_edge();
    test_restart();
    test_busy_ignore();
    test_reset_in_commit();
    test_load_with_start();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
